// File: rtl/ascensor_pkg.sv
// Shared elevator types: floor width, door constants and call-map helpers.
// Imported by gestor_llamadas and maquina_estados.
package ascensor_pkg;

   localparam int N_PISOS = 4;
   localparam int PISO_W  = 2;

   typedef logic [PISO_W-1:0]  piso_t;
   typedef logic [N_PISOS-1:0] mapa_t;

   localparam logic PUERTA_ABIERTA = 1'b1;
   localparam logic PUERTA_CERRADA = 1'b0;

   function automatic mapa_t mascara_sobre(input piso_t p);
      mapa_t m;
      m = '0;
      for (int f = 0; f < N_PISOS; f++) begin
         if (f > int'(p)) m[f] = 1'b1;
      end
      return m;
   endfunction

   function automatic mapa_t mascara_bajo(input piso_t p);
      mapa_t m;
      m = '0;
      for (int f = 0; f < N_PISOS; f++) begin
         if (f < int'(p)) m[f] = 1'b1;
      end
      return m;
   endfunction

   // Returns {found, floor}: nearest call strictly beyond p in the given sense.
   function automatic logic [PISO_W:0] buscar(
      input mapa_t m,
      input piso_t p,
      input logic  sube
   );
      logic [PISO_W:0] r;
      r = '0;
      if (sube) begin
         for (int f = N_PISOS - 1; f >= 0; f--) begin
            if (f > int'(p) && m[f]) r = {1'b1, piso_t'(f)};
         end
      end else begin
         for (int f = 0; f < N_PISOS; f++) begin
            if (f < int'(p) && m[f]) r = {1'b1, piso_t'(f)};
         end
      end
      return r;
   endfunction

endpackage

// File: rtl/sincronizador_boton.sv
// One button path: 2-FF synchroniser, optional debounce, single-pulse edge.
// Debounce is built only when GESTOR_DEBOUNCE_EN is defined.
module sincronizador_boton
`ifdef GESTOR_DEBOUNCE_EN
#(
   parameter int DEB_CYCLES = 16
)
`endif
(
   input  logic clk,
   input  logic rst,
   input  logic boton,
   output logic pulso
);

   logic s1_q, s2_q;
   logic prev_q;
   logic vivo_q, armado_q;
   logic nivel;

   // armado_q blocks a press already held across reset until it is released.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         s1_q     <= 1'b0;
         s2_q     <= 1'b0;
         prev_q   <= 1'b0;
         vivo_q   <= 1'b0;
         armado_q <= 1'b0;
      end else begin
         s1_q   <= boton;
         s2_q   <= s1_q;
         prev_q <= nivel;
         vivo_q <= 1'b1;
         if (vivo_q && !s1_q) armado_q <= 1'b1;
      end
   end

`ifdef GESTOR_DEBOUNCE_EN
   logic [7:0] cnt_q, cnt_d;
   logic       deb_q, deb_d;

   always_comb begin
      cnt_d = '0;
      deb_d = deb_q;
      if (s2_q != deb_q) begin
         if (cnt_q == 8'(DEB_CYCLES - 1)) deb_d = s2_q;
         else cnt_d = cnt_q + 8'd1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_q <= '0;
         deb_q <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         deb_q <= deb_d;
      end
   end

   assign nivel = deb_q;
`else
   assign nivel = s2_q;
`endif

   assign pulso = nivel & ~prev_q & armado_q;

endmodule

// File: rtl/gestor_llamadas.sv
// Call manager: latches floor calls and picks a SCAN target each cycle.
// Optional button debounce selected by GESTOR_DEBOUNCE_EN.
module gestor_llamadas
   import ascensor_pkg::*;
#(
   parameter int DEB_CYCLES = 16
)
(
   input  logic               clk,
   input  logic               rst,
   input  logic               en,
   input  logic [N_PISOS-1:0] boton_pres,
   input  piso_t              piso,
   input  logic               puertas,
   output logic [N_PISOS-1:0] pendientes,
   output piso_t              objetivo,
   output logic               objetivo_valido,
   output logic               dir_sube
);

   if (DEB_CYCLES < 2 || DEB_CYCLES > 255) begin : g_deb_rango
      $error("DEB_CYCLES must lie in 2..255");
   end

   mapa_t pulso;

   for (genvar i = 0; i < N_PISOS; i++) begin : g_boton
      sincronizador_boton
`ifdef GESTOR_DEBOUNCE_EN
         #(.DEB_CYCLES(DEB_CYCLES))
`endif
         u_sinc (
            .clk   (clk),
            .rst   (rst),
            .boton (boton_pres[i]),
            .pulso (pulso[i])
         );
   end

   mapa_t           pend_q, pend_d;
   logic            dir_q, dir_d;
   piso_t           obj_q, obj_d;
   logic            val_q, val_d;
   mapa_t           borrar;
   logic            sobre, bajo;
   logic [PISO_W:0] prim, seg;

   always_comb begin
      pend_d = pend_q;
      dir_d  = dir_q;
      obj_d  = obj_q;
      val_d  = val_q;
      borrar = '0;
      sobre  = 1'b0;
      bajo   = 1'b0;
      prim   = '0;
      seg    = '0;
      if (puertas == PUERTA_ABIERTA) borrar[piso] = 1'b1;
      if (en) begin
         // Clear wins over a same-cycle press at the open-door floor.
         pend_d = (pend_q | pulso) & ~borrar;
         sobre  = |(pend_d & mascara_sobre(piso));
         bajo   = |(pend_d & mascara_bajo(piso));
         if (dir_q) dir_d = sobre | ~bajo;
         else       dir_d = sobre & ~bajo;
         prim  = buscar(pend_d, piso, dir_d);
         seg   = buscar(pend_d, piso, ~dir_d);
         val_d = |pend_d;
         if (pend_d[piso])        obj_d = piso;
         else if (prim[PISO_W])   obj_d = prim[PISO_W-1:0];
         else if (seg[PISO_W])    obj_d = seg[PISO_W-1:0];
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pend_q <= '0;
         dir_q  <= 1'b1;
         obj_q  <= '0;
         val_q  <= 1'b0;
      end else begin
         pend_q <= pend_d;
         dir_q  <= dir_d;
         obj_q  <= obj_d;
         val_q  <= val_d;
      end
   end

   assign pendientes      = pend_q;
   assign objetivo        = obj_q;
   assign objetivo_valido = val_q;
   assign dir_sube        = dir_q;

endmodule
